hs_npu_axi_burst_responder: RTL and testbench
=============================================

# hs_npu_axi_burst_responder

AXI4 burst slave with on-chip word storage, the responder end of the NPU memory interface's burst master. It serves the INCR bursts issued by the NPU, 32-bit words with `arsize`/`awsize`=2 and `arlen`/`awlen`=1 by default, so the memory path can run standalone in simulation and on FPGA without external DRAM. Read and write channels are independent. Storage is a 1R1W word array with byte enables.

## Interface
- `BASE_ADDR`, default 32'h0000_0000. Byte address of word 0.
- `DEPTH_WORDS`, default 1024. Number of 32-bit words; must be a power of two.
- `clk`  in  1  clock.
- `rst`  in  1  reset. Asynchronous and active-high; one clock in the block.
- `axi`  slave modport  —  `axib_if.s`: AR/R/AW/W/B channels, 32-bit addr/data, 8-bit len, 3-bit size, 2-bit burst/resp, 4-bit wstrb.

## Operation
- Word index is `(addr - BASE_ADDR) >> 2`. A beat is in range iff `BASE_ADDR <= addr` and index `< DEPTH_WORDS`. Range is decoded per beat.
- Burst types:
  - INCR: address advances by 4 per beat.
  - FIXED: address is held for the whole burst.
  - WRAP, or size ≠ 2: burst still runs its full length, every beat gets SLVERR, and no storage access occurs.
- Out-of-range beat:
  - read: `rdata`=0, `rresp`=SLVERR.
  - write: data dropped, and the burst's `bresp` becomes SLVERR.
- Read FSM:
  - R_IDLE: `arready`=1. On AR handshake, capture addr/len/burst, load `rdata` from the first beat, set `rvalid`=1, go to R_BURST.
  - R_BURST: `arready`=0, `rvalid`=1. On `rready`:
    - if beat == len: drop `rvalid`, return to R_IDLE.
    - else: advance the address and load the next word.
  - `rlast`=1 iff beat == len.
- Write FSM:
  - W_IDLE: `awready`=1. On AW handshake, capture addr/len/burst, go to W_DATA.
  - W_DATA: `wready`=1. Each W handshake writes the bytes enabled by `wstrb`. The burst ends after len+1 beats; `wlast` is not used to terminate.
    - `wlast` low on the final beat, or high early: `bresp`=SLVERR.
    - After the final beat, go to W_RESP.
  - W_RESP: `bvalid`=1 with the accumulated `bresp`; on `bready`, go to W_IDLE.
- The W channel is accepted only after the AW handshake; W beats arriving earlier wait.
- Simultaneous read and write to the same word in the same cycle: the read returns the old data (read-first).

## Timing
- Reset values: `arready`=0, `awready`=0, `rvalid`=0, `wready`=0, `bvalid`=0, `rlast`=0, `rdata`=0, `rresp`=OKAY, `bresp`=OKAY; FSMs in idle. `arready` and `awready` assert the first cycle after `rst` deasserts.
- Storage contents are not reset.
- Read: AR handshake in cycle N puts the first R beat valid in cycle N+1. One beat per cycle while `rready`=1. One idle cycle between back-to-back bursts.
- `rdata`, `rresp` and `rlast` are held stable while `rvalid`=1 and `rready`=0.
- Write: AW handshake in N makes `wready`=1 in N+1. A write is visible to a read issued the cycle after the W handshake. `bvalid` asserts the cycle after the last W handshake.
- `len`=0 gives single-beat bursts. `len`=255 needs an 8-bit beat counter with no wrap. An INCR burst past the top of storage returns SLVERR on the overflowing beats only.
- `rst` asserted mid-burst: both FSMs abort to idle asynchronously and all valids drop. Storage writes already committed remain.

## Structure
- `hs_npu_pkg` additions:
  - `axi_resp_t` (OKAY=2'b00, SLVERR=2'b10).
  - `axi_burst_t` (FIXED=2'b00, INCR=2'b01, WRAP=2'b10).
  - `AXI_SIZE_WORD`=3'd2.
- Sub-module `hs_npu_axi_word_ram`: synchronous 1R1W, byte-enable write, read-first, `DEPTH_WORDS` parameter. The top-level block holds the two FSMs, beat counters and address/response logic.

## Test plan
- Write INCR `awaddr`=0x10, len=1, data 0xDEADBEEF/0x12345678, strb 4'hF, then read 0x10 len=1. Required: `bresp`=OKAY; R beats in the same order, `rlast` on beat 2, `rresp`=OKAY.
- Read len=3 with `rready` toggling 1,0,0,1,…. Required: `rdata` holds during stalls, exactly 4 beats, `rlast` only on the 4th.
- Write `wstrb`=4'b0101 of 0xAABBCCDD over 0x11111111. Required: readback 0x11BB11DD.
- INCR len=1 at byte address `(DEPTH_WORDS-1)*4`. Required: read beat 1 OKAY, beat 2 SLVERR with data 0; write `bresp`=SLVERR and the in-range word is written.
- FIXED write len=3 with data 1,2,3,4 at 0x40, then INCR read at 0x40. Required: word 0x40 = 4 and 0x44 untouched; WRAP burst returns SLVERR on all beats.
- `rst` pulsed during beat 2 of a len=3 read. Required: `rvalid` is 0 immediately, `arready`=1 the cycle after release, and a new read returns correct data.

Source files
------------

// File: rtl/hs_npu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hs_npu_pkg
//  Brief    : Shared AXI encodings and FSM state types for the NPU memory path.
//  Revision : 1.0 - initial release
// ============================================================================
package hs_npu_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } axi_resp_t;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } axi_burst_t;

    localparam logic [2:0] AXI_SIZE_WORD = 3'd2;

    typedef enum logic [0:0] {
        R_IDLE  = 1'b0,
        R_BURST = 1'b1
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } wr_state_t;

endpackage
`default_nettype wire

// File: rtl/axib_if.sv
`default_nettype none
// ============================================================================
//  Module   : axib_if
//  Brief    : AXI4 burst bus (AR/R/AW/W/B), 32-bit address and data.
//  Revision : 1.0 - initial release
// ============================================================================
interface axib_if;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport s (
        input  araddr, arlen, arsize, arburst, arvalid, rready,
        input  awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        output arready, rdata, rresp, rlast, rvalid,
        output awready, wready, bresp, bvalid
    );

    modport m (
        output araddr, arlen, arsize, arburst, arvalid, rready,
        output awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        input  arready, rdata, rresp, rlast, rvalid,
        input  awready, wready, bresp, bvalid
    );
endinterface
`default_nettype wire

// File: rtl/hs_npu_axi_word_ram.sv
`default_nettype none
// ============================================================================
//  Module   : hs_npu_axi_word_ram
//  Brief    : Synchronous 1R1W 32-bit word store, byte-enable write, read-first.
//  Revision : 1.0 - initial release
// ============================================================================
module hs_npu_axi_word_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             i_re,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [31:0]      o_rdata,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [3:0]       i_wbe,
    input  logic [31:0]      i_wdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    // Read and write share one process so a same-word access returns old data.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we && i_wbe[b]) begin
                r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/hs_npu_axi_burst_responder.sv
`default_nettype none
// ============================================================================
//  Module   : hs_npu_axi_burst_responder
//  Brief    : AXI4 burst slave backed by on-chip word storage; independent
//             read and write channel FSMs with per-beat range decode.
//  Revision : 1.0 - initial release
// ============================================================================
module hs_npu_axi_burst_responder
    import hs_npu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024
) (
    input  logic clk,
    input  logic rst,
    axib_if.s    axi
);

    localparam int          c_IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] c_SPAN_BYTES = 32'(DEPTH_WORDS * 4);

    function automatic logic in_range(input logic [31:0] a);
        return (a >= BASE_ADDR) && ((a - BASE_ADDR) < c_SPAN_BYTES);
    endfunction

    function automatic logic [c_IDX_W-1:0] word_idx(input logic [31:0] a);
        return c_IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    function automatic logic bad_burst(input logic [1:0] burst, input logic [2:0] size);
        return !((burst == INCR) || (burst == FIXED)) || (size != AXI_SIZE_WORD);
    endfunction

    // Address channels stay closed until the first edge after reset release.
    logic r_ready_en;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_ready_en <= 1'b0;
        else     r_ready_en <= 1'b1;
    end

    // ---------------------------------------------------------------- read
    rd_state_t   r_rd_state, w_rd_next;
    logic [31:0] r_rd_addr, w_rd_addr;
    logic [7:0]  r_rd_len, r_rd_beat;
    logic        r_rd_fixed, r_rd_bad, r_rd_err;
    logic        w_rd_load, w_rd_bad, w_rd_beat_err, w_rd_last;
    logic [31:0] w_ram_rdata;

    assign w_rd_last = (r_rd_beat == r_rd_len);

    always_comb begin
        w_rd_next = r_rd_state;
        w_rd_load = 1'b0;
        w_rd_addr = r_rd_addr;
        w_rd_bad  = r_rd_bad;
        case (r_rd_state)
            R_IDLE: begin
                if (r_ready_en && axi.arvalid) begin
                    w_rd_next = R_BURST;
                    w_rd_load = 1'b1;
                    w_rd_addr = axi.araddr;
                    w_rd_bad  = bad_burst(axi.arburst, axi.arsize);
                end
            end
            R_BURST: begin
                if (axi.rready) begin
                    if (w_rd_last) begin
                        w_rd_next = R_IDLE;
                    end else begin
                        w_rd_load = 1'b1;
                        w_rd_addr = r_rd_fixed ? r_rd_addr : r_rd_addr + 32'd4;
                    end
                end
            end
            default: w_rd_next = R_IDLE;
        endcase
        w_rd_beat_err = w_rd_bad || !in_range(w_rd_addr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_state <= R_IDLE;
            r_rd_addr  <= '0;
            r_rd_len   <= '0;
            r_rd_beat  <= '0;
            r_rd_fixed <= 1'b0;
            r_rd_bad   <= 1'b0;
            r_rd_err   <= 1'b0;
        end else begin
            r_rd_state <= w_rd_next;
            if (w_rd_load) begin
                r_rd_addr <= w_rd_addr;
                r_rd_err  <= w_rd_beat_err;
            end
            if (r_rd_state == R_IDLE && w_rd_load) begin
                r_rd_len   <= axi.arlen;
                r_rd_beat  <= '0;
                r_rd_fixed <= (axi.arburst == FIXED);
                r_rd_bad   <= w_rd_bad;
            end else if (w_rd_load) begin
                r_rd_beat <= r_rd_beat + 8'd1;
            end
        end
    end

    assign axi.arready = r_ready_en && (r_rd_state == R_IDLE);
    assign axi.rvalid  = (r_rd_state == R_BURST);
    assign axi.rlast   = axi.rvalid && w_rd_last;
    assign axi.rresp   = r_rd_err ? SLVERR : OKAY;
    assign axi.rdata   = (axi.rvalid && !r_rd_err) ? w_ram_rdata : 32'd0;

    // --------------------------------------------------------------- write
    wr_state_t   r_wr_state, w_wr_next;
    logic [31:0] r_wr_addr;
    logic [7:0]  r_wr_len, r_wr_beat;
    logic        r_wr_fixed, r_wr_bad, r_wr_err;
    logic        w_aw_hs, w_w_hs, w_wr_last, w_wr_beat_err;

    assign w_aw_hs       = axi.awready && axi.awvalid;
    assign w_wr_last     = (r_wr_beat == r_wr_len);
    assign w_wr_beat_err = r_wr_bad || !in_range(r_wr_addr);

    always_comb begin
        w_wr_next = r_wr_state;
        w_w_hs    = 1'b0;
        case (r_wr_state)
            W_IDLE: begin
                if (w_aw_hs) w_wr_next = W_DATA;
            end
            W_DATA: begin
                if (axi.wvalid) begin
                    w_w_hs = 1'b1;
                    if (w_wr_last) w_wr_next = W_RESP;
                end
            end
            W_RESP: begin
                if (axi.bready) w_wr_next = W_IDLE;
            end
            default: w_wr_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_state <= W_IDLE;
            r_wr_addr  <= '0;
            r_wr_len   <= '0;
            r_wr_beat  <= '0;
            r_wr_fixed <= 1'b0;
            r_wr_bad   <= 1'b0;
            r_wr_err   <= 1'b0;
        end else begin
            r_wr_state <= w_wr_next;
            if (w_aw_hs) begin
                r_wr_addr  <= axi.awaddr;
                r_wr_len   <= axi.awlen;
                r_wr_beat  <= '0;
                r_wr_fixed <= (axi.awburst == FIXED);
                r_wr_bad   <= bad_burst(axi.awburst, axi.awsize);
                r_wr_err   <= 1'b0;
            end else if (w_w_hs) begin
                // wlast only grades the burst; the beat count alone ends it.
                r_wr_err <= r_wr_err | w_wr_beat_err | (axi.wlast != w_wr_last);
                if (!w_wr_last) begin
                    r_wr_beat <= r_wr_beat + 8'd1;
                    r_wr_addr <= r_wr_fixed ? r_wr_addr : r_wr_addr + 32'd4;
                end
            end
        end
    end

    assign axi.awready = r_ready_en && (r_wr_state == W_IDLE);
    assign axi.wready  = (r_wr_state == W_DATA);
    assign axi.bvalid  = (r_wr_state == W_RESP);
    assign axi.bresp   = r_wr_err ? SLVERR : OKAY;

    hs_npu_axi_word_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (c_IDX_W)
    ) u_ram (
        .clk     (clk),
        .i_re    (w_rd_load && !w_rd_beat_err),
        .i_raddr (word_idx(w_rd_addr)),
        .o_rdata (w_ram_rdata),
        .i_we    (w_w_hs && !w_wr_beat_err),
        .i_waddr (word_idx(r_wr_addr)),
        .i_wbe   (axi.wstrb),
        .i_wdata (axi.wdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_hs_npu_axi_burst_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hs_npu_axi_burst_responder
//  Brief    : Directed self-checking bench for the AXI burst responder.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_hs_npu_axi_burst_responder;
    import hs_npu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axib_if axi_bus();

    hs_npu_axi_burst_responder #(
        .BASE_ADDR   (32'h0000_0000),
        .DEPTH_WORDS (1024)
    ) dut (
        .clk (clk),
        .rst (rst),
        .axi (axi_bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] wd [0:255];
    logic [3:0]  ws [0:255];
    logic [31:0] rd_data [0:255];
    logic [1:0]  rd_resp [0:255];
    logic        rd_last [0:255];
    int          rd_n, rd_lat, hold_viol;
    logic [1:0]  b_resp;
    int          b_wait;

    task automatic bus_idle();
        axi_bus.araddr = '0; axi_bus.arlen = '0; axi_bus.arsize = 3'd2; axi_bus.arburst = 2'b01;
        axi_bus.arvalid = 1'b0; axi_bus.rready = 1'b0;
        axi_bus.awaddr = '0; axi_bus.awlen = '0; axi_bus.awsize = 3'd2; axi_bus.awburst = 2'b01;
        axi_bus.awvalid = 1'b0;
        axi_bus.wdata = '0; axi_bus.wstrb = '0; axi_bus.wlast = 1'b0; axi_bus.wvalid = 1'b0;
        axi_bus.bready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [2:0] size, input bit bad_wlast,
                            output logic [1:0] resp, output int bwait);
        int cnt;
        @(negedge clk);
        axi_bus.awaddr = addr; axi_bus.awlen = len; axi_bus.awburst = burst; axi_bus.awsize = size;
        axi_bus.awvalid = 1'b1;
        cnt = 0;
        while (!axi_bus.awready && cnt < 100) begin @(negedge clk); cnt++; end
        if (cnt >= 100) begin
            checks++; errors++;
            $display("FAIL aw_timeout: awready=%0b required 1", axi_bus.awready);
        end
        @(negedge clk);
        axi_bus.awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            axi_bus.wdata  = wd[b];
            axi_bus.wstrb  = ws[b];
            axi_bus.wlast  = (b == int'(len)) && !bad_wlast;
            axi_bus.wvalid = 1'b1;
            cnt = 0;
            while (!axi_bus.wready && cnt < 100) begin @(negedge clk); cnt++; end
            if (cnt >= 100) begin
                checks++; errors++;
                $display("FAIL w_timeout: wready=%0b required 1", axi_bus.wready);
            end
            @(negedge clk);
        end
        axi_bus.wvalid = 1'b0;
        axi_bus.wlast  = 1'b0;
        axi_bus.bready = 1'b1;
        bwait = 0;
        while (!axi_bus.bvalid && bwait < 100) begin @(negedge clk); bwait++; end
        if (bwait >= 100) begin
            checks++; errors++;
            $display("FAIL b_timeout: bvalid=%0b required 1", axi_bus.bvalid);
        end
        resp = axi_bus.bresp;
        @(negedge clk);
        axi_bus.bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input logic [3:0] pat);
        int cnt, cyc;
        bit stall;
        logic [31:0] pd;
        logic [1:0]  pr;
        logic        pl;
        @(negedge clk);
        axi_bus.araddr = addr; axi_bus.arlen = len; axi_bus.arburst = burst; axi_bus.arsize = size;
        axi_bus.arvalid = 1'b1;
        cnt = 0;
        while (!axi_bus.arready && cnt < 100) begin @(negedge clk); cnt++; end
        if (cnt >= 100) begin
            checks++; errors++;
            $display("FAIL ar_timeout: arready=%0b required 1", axi_bus.arready);
        end
        @(negedge clk);
        axi_bus.arvalid = 1'b0;
        rd_n = 0; rd_lat = -1; hold_viol = 0; stall = 1'b0; cyc = 0;
        pd = '0; pr = '0; pl = 1'b0;
        while (rd_n <= int'(len) && cyc < 300) begin
            if (stall && (axi_bus.rvalid !== 1'b1 || axi_bus.rdata !== pd ||
                          axi_bus.rresp !== pr || axi_bus.rlast !== pl))
                hold_viol++;
            if (axi_bus.rvalid && rd_lat < 0) rd_lat = cyc;
            axi_bus.rready = pat[cyc[1:0]];
            if (axi_bus.rvalid && axi_bus.rready) begin
                rd_data[rd_n] = axi_bus.rdata;
                rd_resp[rd_n] = axi_bus.rresp;
                rd_last[rd_n] = axi_bus.rlast;
                rd_n++;
            end
            stall = axi_bus.rvalid && !axi_bus.rready;
            pd = axi_bus.rdata; pr = axi_bus.rresp; pl = axi_bus.rlast;
            @(negedge clk);
            cyc++;
        end
        axi_bus.rready = 1'b0;
        if (cyc >= 300) begin
            checks++; errors++;
            $display("FAIL r_timeout: beats=%0d required %0d", rd_n, int'(len) + 1);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (axi_bus.arready !== 1'b0) begin errors++; $display("FAIL rst_arready: got %b want 0", axi_bus.arready); end
        checks++; if (axi_bus.awready !== 1'b0) begin errors++; $display("FAIL rst_awready: got %b want 0", axi_bus.awready); end
        checks++; if (axi_bus.rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b want 0", axi_bus.rvalid); end
        checks++; if (axi_bus.wready !== 1'b0) begin errors++; $display("FAIL rst_wready: got %b want 0", axi_bus.wready); end
        checks++; if (axi_bus.bvalid !== 1'b0) begin errors++; $display("FAIL rst_bvalid: got %b want 0", axi_bus.bvalid); end
        checks++; if (axi_bus.rlast !== 1'b0) begin errors++; $display("FAIL rst_rlast: got %b want 0", axi_bus.rlast); end
        checks++; if (axi_bus.rdata !== 32'd0) begin errors++; $display("FAIL rst_rdata: got %h want 0", axi_bus.rdata); end
        checks++; if (axi_bus.rresp !== 2'b00) begin errors++; $display("FAIL rst_rresp: got %b want 00", axi_bus.rresp); end
        checks++; if (axi_bus.bresp !== 2'b00) begin errors++; $display("FAIL rst_bresp: got %b want 00", axi_bus.bresp); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (axi_bus.arready !== 1'b1) begin errors++; $display("FAIL rel_arready: got %b want 1", axi_bus.arready); end
        checks++; if (axi_bus.awready !== 1'b1) begin errors++; $display("FAIL rel_awready: got %b want 1", axi_bus.awready); end
    endtask

    task automatic test_incr();
        wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
        wd[1] = 32'h1234_5678; ws[1] = 4'hF;
        do_write(32'h10, 8'd1, 2'b01, 3'd2, 1'b0, b_resp, b_wait);
        checks++; if (b_resp !== 2'b00) begin errors++; $display("FAIL incr_bresp: got %b want 00", b_resp); end
        checks++; if (b_wait !== 0) begin errors++; $display("FAIL incr_bvalid_lat: got %0d want 0", b_wait); end
        do_read(32'h10, 8'd1, 2'b01, 3'd2, 4'b1111);
        checks++; if (rd_lat !== 0) begin errors++; $display("FAIL incr_rvalid_lat: got %0d want 0", rd_lat); end
        checks++; if (rd_n !== 2) begin errors++; $display("FAIL incr_beats: got %0d want 2", rd_n); end
        checks++; if (rd_data[0] !== 32'hDEAD_BEEF || rd_data[1] !== 32'h1234_5678) begin
            errors++; $display("FAIL incr_data: got %h %h want deadbeef 12345678", rd_data[0], rd_data[1]); end
        checks++; if (rd_last[0] !== 1'b0 || rd_last[1] !== 1'b1) begin
            errors++; $display("FAIL incr_rlast: got %b%b want 01", rd_last[0], rd_last[1]); end
        checks++; if (rd_resp[0] !== 2'b00 || rd_resp[1] !== 2'b00) begin
            errors++; $display("FAIL incr_rresp: got %b %b want 00 00", rd_resp[0], rd_resp[1]); end
    endtask

    task automatic test_read_stall();
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hC0DE_0000 | 32'(i); ws[i] = 4'hF; end
        do_write(32'h100, 8'd3, 2'b01, 3'd2, 1'b0, b_resp, b_wait);
        do_read(32'h100, 8'd3, 2'b01, 3'd2, 4'b1001);
        checks++; if (rd_n !== 4) begin errors++; $display("FAIL stall_beats: got %0d want 4", rd_n); end
        checks++; if (hold_viol !== 0) begin errors++; $display("FAIL stall_hold: got %0d changes want 0", hold_viol); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_data[i] !== (32'hC0DE_0000 | 32'(i)) || rd_last[i] !== (i == 3)) begin
                errors++; $display("FAIL stall_beat%0d: got data %h last %b want %h last %b",
                                   i, rd_data[i], rd_last[i], 32'hC0DE_0000 | 32'(i), i == 3);
            end
        end
        checks++; if (axi_bus.rvalid !== 1'b0) begin errors++; $display("FAIL stall_extra: rvalid %b want 0", axi_bus.rvalid); end
    endtask

    task automatic test_strobe();
        wd[0] = 32'h1111_1111; ws[0] = 4'hF;
        do_write(32'h200, 8'd0, 2'b01, 3'd2, 1'b0, b_resp, b_wait);
        wd[0] = 32'hAABB_CCDD; ws[0] = 4'b0101;
        do_write(32'h200, 8'd0, 2'b01, 3'd2, 1'b0, b_resp, b_wait);
        do_read(32'h200, 8'd0, 2'b01, 3'd2, 4'b1111);
        checks++; if (rd_data[0] !== 32'h11BB_11DD) begin errors++; $display("FAIL strobe_data: got %h want 11bb11dd", rd_data[0]); end
    endtask

    task automatic test_boundary();
        wd[0] = 32'hCAFE_F00D; ws[0] = 4'hF;
        wd[1] = 32'h0BAD_BEEF; ws[1] = 4'hF;
        do_write(32'hFFC, 8'd1, 2'b01, 3'd2, 1'b0, b_resp, b_wait);
        checks++; if (b_resp !== 2'b10) begin errors++; $display("FAIL bound_bresp: got %b want 10", b_resp); end
        do_read(32'hFFC, 8'd1, 2'b01, 3'd2, 4'b1111);
        checks++; if (rd_resp[0] !== 2'b00 || rd_data[0] !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL bound_beat1: got %b %h want 00 cafef00d", rd_resp[0], rd_data[0]); end
        checks++; if (rd_resp[1] !== 2'b10 || rd_data[1] !== 32'd0) begin
            errors++; $display("FAIL bound_beat2: got %b %h want 10 00000000", rd_resp[1], rd_data[1]); end
    endtask

    task automatic test_fixed_wrap();
        wd[0] = 32'h5555_5555; ws[0] = 4'hF;
        do_write(32'h44, 8'd0, 2'b01, 3'd2, 1'b0, b_resp, b_wait);
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        do_write(32'h40, 8'd3, 2'b00, 3'd2, 1'b0, b_resp, b_wait);
        checks++; if (b_resp !== 2'b00) begin errors++; $display("FAIL fixed_bresp: got %b want 00", b_resp); end
        do_read(32'h40, 8'd1, 2'b01, 3'd2, 4'b1111);
        checks++; if (rd_data[0] !== 32'd4 || rd_data[1] !== 32'h5555_5555) begin
            errors++; $display("FAIL fixed_data: got %h %h want 00000004 55555555", rd_data[0], rd_data[1]); end
        do_read(32'h40, 8'd3, 2'b10, 3'd2, 4'b1111);
        checks++; if (rd_n !== 4) begin errors++; $display("FAIL wrap_beats: got %0d want 4", rd_n); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_resp[i] !== 2'b10 || rd_data[i] !== 32'd0) begin
                errors++; $display("FAIL wrap_beat%0d: got %b %h want 10 00000000", i, rd_resp[i], rd_data[i]);
            end
        end
        do_read(32'h40, 8'd0, 2'b01, 3'd1, 4'b1111);
        checks++; if (rd_resp[0] !== 2'b10) begin errors++; $display("FAIL size_rresp: got %b want 10", rd_resp[0]); end
        wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
        do_write(32'h40, 8'd0, 2'b10, 3'd2, 1'b0, b_resp, b_wait);
        checks++; if (b_resp !== 2'b10) begin errors++; $display("FAIL wrap_bresp: got %b want 10", b_resp); end
        do_read(32'h40, 8'd0, 2'b01, 3'd2, 4'b1111);
        checks++; if (rd_data[0] !== 32'd4) begin errors++; $display("FAIL wrap_nowrite: got %h want 00000004", rd_data[0]); end
    endtask

    task automatic test_wlast();
        wd[0] = 32'h0; ws[0] = 4'hF;
        wd[1] = 32'h0; ws[1] = 4'hF;
        do_write(32'h300, 8'd1, 2'b01, 3'd2, 1'b1, b_resp, b_wait);
        checks++; if (b_resp !== 2'b10) begin errors++; $display("FAIL wlast_bresp: got %b want 10", b_resp); end
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        axi_bus.araddr = 32'h100; axi_bus.arlen = 8'd3; axi_bus.arburst = 2'b01; axi_bus.arsize = 3'd2;
        axi_bus.arvalid = 1'b1;
        @(negedge clk);
        axi_bus.arvalid = 1'b0;
        axi_bus.rready  = 1'b1;
        @(negedge clk);
        checks++; if (axi_bus.rvalid !== 1'b1 || axi_bus.rdata !== 32'hC0DE_0001) begin
            errors++; $display("FAIL mid_beat2: got valid %b data %h want 1 c0de0001", axi_bus.rvalid, axi_bus.rdata); end
        axi_bus.rready = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++; if (axi_bus.rvalid !== 1'b0) begin errors++; $display("FAIL mid_rvalid: got %b want 0", axi_bus.rvalid); end
        checks++; if (axi_bus.arready !== 1'b0) begin errors++; $display("FAIL mid_arready_rst: got %b want 0", axi_bus.arready); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (axi_bus.arready !== 1'b1) begin errors++; $display("FAIL mid_arready_rel: got %b want 1", axi_bus.arready); end
        do_read(32'h108, 8'd0, 2'b01, 3'd2, 4'b1111);
        checks++; if (rd_n !== 1 || rd_data[0] !== 32'hC0DE_0002 || rd_resp[0] !== 2'b00) begin
            errors++; $display("FAIL mid_reread: got %0d beats %h %b want 1 c0de0002 00", rd_n, rd_data[0], rd_resp[0]); end
    endtask

    initial begin
        bus_idle();
        test_reset();
        test_incr();
        test_read_stall();
        test_strobe();
        test_boundary();
        test_fixed_wrap();
        test_wlast();
        test_reset_mid_burst();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
